// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up in FIX.
module ex_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic            flush,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic word_q, neg_q, neg_r, dz;
  logic [6:0] cnt;
  logic [XLEN-1:0] x1, mpl, quo, dvs;
  logic [2*XLEN-1:0] prod, mcd;
  logic [XLEN:0] rem, sh, diff;
  logic s1, s2, n1, n2;
  logic [XLEN-1:0] e1, e2, m1, m2, q_fix, r_fix, sel;
  logic [2*XLEN-1:0] p_fix;
  assign s1 = op[2] ? ~op[0] : ~(op[1] & op[0]);
  assign s2 = op[2] ? ~op[0] : ~op[1];
  assign e1 = word ? {{(XLEN-32){s1 & op1[31]}}, op1[31:0]} : op1;
  assign e2 = word ? {{(XLEN-32){s2 & op2[31]}}, op2[31:0]} : op2;
  assign n1 = s1 & e1[XLEN-1];
  assign n2 = s2 & e2[XLEN-1];
  assign m1 = n1 ? -e1 : e1;
  assign m2 = n2 ? -e2 : e2;
  // one restoring-division step: a borrow out of bit XLEN means the divisor did not fit
  assign sh = {rem[XLEN-1:0], quo[XLEN-1]};
  assign diff = sh - {1'b0, dvs};
  assign p_fix = neg_q ? -prod : prod;
  assign q_fix = dz ? '1 : neg_q ? -quo : quo;
  assign r_fix = dz ? x1 : neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign sel = op_q[2] ? (op_q[1] ? r_fix : q_fix) :
               (op_q[1:0] == 2'b00 ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN]);
  assign busy = (state == CALC) | (state == FIX);
  assign done = state == DONE;
  assign stall_req = (start & (state == IDLE)) | busy;
  always_comb
    state_n = flush ? IDLE :
              state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (cnt == 7'd1 ? FIX : CALC) :
              state == FIX ? DONE : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      word_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      x1 <= '0;
      mpl <= '0;
      quo <= '0;
      dvs <= '0;
      prod <= '0;
      mcd <= '0;
      rem <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start && !flush) begin
        op_q <= op;
        word_q <= word;
        neg_q <= n1 ^ n2;
        neg_r <= n1;
        dz <= e2 == '0;
        x1 <= e1;
        cnt <= word ? 7'd32 : 7'd64;
        prod <= '0;
        mcd <= {{XLEN{1'b0}}, m1};
        mpl <= m2;
        rem <= '0;
        quo <= word ? {m1[31:0], {(XLEN-32){1'b0}}} : m1;
        dvs <= m2;
      end else if (state == CALC && !flush) begin
        cnt <= cnt - 7'd1;
        if (mpl[0]) prod <= prod + mcd;
        mcd <= mcd << 1;
        mpl <= mpl >> 1;
        rem <= diff[XLEN] ? sh : diff;
        quo <= {quo[XLEN-2:0], ~diff[XLEN]};
      end
      if (state == FIX && !flush) result <= word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv; stimulus pushes expected results, a monitor checks each done.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = '0;
  logic word = 1'b0;
  logic flush = 1'b0;
  logic [63:0] op1 = '0;
  logic [63:0] op2 = '0;
  logic stall_req, busy, done;
  logic [63:0] result;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string name_q[$];
  logic [63:0] last_exp = '0;

  ex_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .word(word), .flush(flush),
    .op1(op1), .op2(op2), .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", result, 64'hx);
      else chk(name_q.pop_front(), result, exp_q.pop_front());
    end
  end

  task automatic run(input string nm, input logic [2:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] e, input int lat);
    int dc;
    int bad;
    @(negedge clk);
    op = o; word = w; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_exp = e;
    bad = 0;
    dc = -1;
    for (int k = 1; k <= lat + 4 && dc < 0; k++) begin
      @(negedge clk);
      if (stall_req !== (k != lat)) bad++;
      if (done) dc = k;
    end
    start = 1'b0;
    chk({"latency ", nm}, dc, lat);
    chk({"stall ", nm}, bad, 0);
  endtask

  task automatic abort(input logic use_rst);
    int nd;
    @(negedge clk);
    op = 3'b100; word = 1'b0; op1 = -64'sd7; op2 = 64'd2; start = 1'b1;
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall_req, 0);
    chk("abort_done", done, 0);
    nd = 0;
    repeat (69) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_result", result, use_rst ? 64'd0 : last_exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall_req, 0);
    chk("reset_result", result, 0);
    run("mul", 3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, 66);
    run("mulhu", 3'b011, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 66);
    run("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66);
    run("mulh", 3'b001, 1'b0, 64'h4000000000000000, 64'd4, 64'd1, 66);
    run("div", 3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66);
    run("rem", 3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66);
    run("divu_by0", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 66);
    run("rem_by0", 3'b110, 1'b0, -64'sd5, 64'd0, 64'hFFFFFFFFFFFFFFFB, 66);
    run("div_ovf", 3'b100, 1'b0, 64'h8000000000000000, '1, 64'h8000000000000000, 66);
    run("rem_ovf", 3'b110, 1'b0, 64'h8000000000000000, '1, 64'd0, 66);
    run("divw_ovf", 3'b100, 1'b1, 64'h0000000080000000, '1, 64'hFFFFFFFF80000000, 34);
    run("remuw", 3'b111, 1'b1, 64'h00000000FFFFFFFF, 64'd16, 64'hF, 34);
    run("mulw", 3'b000, 1'b1, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 34);
    run("divuw_by0", 3'b101, 1'b1, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, 34);
    abort(1'b0);
    abort(1'b1);
    run("mul_after_rst", 3'b000, 1'b0, 64'd6, 64'd9, 64'd54, 66);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
